mem_byte_bridge: RTL and testbench
==================================

# mem_byte_bridge

Bridges the core's MEM-stage data-memory port onto an 8-bit external memory bus. Every 32-bit request from the MEM stage (read op, write op, address, byte mask, write data) becomes a sequence of single-byte bus transfers with a ready handshake. The block assembles read data into `rdata` and drives `stallreq` to the pipeline `ctrl` block so the pipeline holds until the access completes.

## Interface
- No parameters. Word is 32 bits, address is 32 bits, external bus is 8 bits.
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `read_op` in 1: MEM-stage load request.
- `write_op` in 1: MEM-stage store request.
- `addr` in 32: request address. Bits [1:0] are ignored; accesses are word-aligned.
- `mask` in 4: store byte enables. Bit i selects byte i (`wdata[8i+7:8i]`). Ignored for reads.
- `wdata` in 32: store data.
- `rdata` out 32: assembled load data, to the MEM stage.
- `stallreq` out 1: stall request to `ctrl`.
- `ext_addr` out 32: byte address on the external bus.
- `ext_wdata` out 8: byte write data.
- `ext_re` out 1: byte read strobe.
- `ext_we` out 1: byte write strobe.
- `ext_rdata` in 8: byte read data. Sampled on the cycle `ext_ready` is 1.
- `ext_ready` in 1: completes the current byte transfer.

## Operation
- FSM with three states: IDLE, XFER, DONE.
- IDLE:
  - On `read_op | write_op`, latch `addr[31:2]`, `mask`, `wdata` and the op; go to XFER.
  - `write_op` has priority when both ops are high.
  - A write with `mask==0` goes directly to DONE with no bus activity.
- XFER:
  - Byte index `idx` (2 bits) starts at 0.
  - Reads visit bytes 0,1,2,3.
  - Writes visit only the bytes whose mask bit is set, in ascending order.
  - `ext_addr = {addr_q[31:2], idx}`. `ext_wdata = wdata_q[8*idx+7:8*idx]`.
  - `ext_re` / `ext_we` stay high until the cycle `ext_ready==1`. In that cycle:
    - reads write `ext_rdata` into `rdata[8*idx+7:8*idx]`;
    - `idx` advances to the next byte to transfer;
    - after the last byte, the FSM goes to DONE.
  - While `ext_ready==0`, `ext_addr`, `ext_wdata` and the strobe hold stable.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - `stallreq` is 0, so the pipeline advances on the closing edge.
  - `read_op`/`write_op` still asserted in DONE are ignored, because they belong to the completed instruction.
- `stallreq = (IDLE & (read_op|write_op)) | XFER`. This is combinational from state and inputs.
- `rdata` holds its value from DONE until the next read's first byte completes. Writes never modify `rdata`.
- Strobes: `ext_re = XFER & !is_write`, `ext_we = XFER & is_write`. At most one is high.
- Reset (asynchronous, any state, including mid-XFER):
  - FSM goes to IDLE.
  - `rdata`, `ext_addr`, `ext_wdata` and the latched fields clear to 0.
  - `ext_re`, `ext_we` and `stallreq` go to 0 immediately.
  - The aborted access is not resumed.

## Timing
- Reset values: `rdata=0`, `stallreq=0` (no request pending), `ext_re=0`, `ext_we=0`, `ext_addr=0`, `ext_wdata=0`.
- The accept cycle (cycle 0) has `stallreq=1` and no strobe. Byte transfers start in cycle 1.
- Latency with N bytes and W total cycles of `ext_ready==0`:
  - DONE occurs in cycle N+W+1;
  - `stallreq` is high for N+W+1 cycles.
- Full-word read with `ext_ready` tied high: strobes in cycles 1-4, DONE in cycle 5, 5 stall cycles.
- A write with `mask==0`: 1 stall cycle, DONE in cycle 1.
- Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE, with no extra bubble.
- `ext_ready` is only sampled in XFER. It is ignored in IDLE and DONE.

## Test plan
- Read of 0x100, external bytes 0x100..0x103 = 11,22,33,44, `ext_ready=1`:
  - `ext_re` in cycles 1-4 with `ext_addr` 0x100..0x103;
  - `rdata=0x44332211` in cycle 5;
  - `stallreq` high in cycles 0-4 only.
- Write to 0x206, `mask=4'b0101`, `wdata=0xAABBCCDD`:
  - exactly two `ext_we` transfers, (0x204, 0xDD) then (0x206, 0xBB);
  - DONE in cycle 3;
  - `rdata` unchanged.
- Read with `ext_ready` held low for 2 cycles during byte 1:
  - `ext_addr` stays 0x..1 for 3 cycles;
  - DONE in cycle 7;
  - `stallreq` high 7 cycles;
  - data correct.
- Write with `mask=0`, then `read_op` and `write_op` both high with `mask=4'b1000`:
  - first: no `ext_we`, 1 stall cycle;
  - second: treated as a write, one byte to `{addr[31:2],2'b11}`, no `ext_re`.
- `RST` pulsed mid-read, while byte 2 is waiting:
  - `ext_re`, `stallreq` and `rdata` go to 0 without waiting for a clock edge;
  - after release, a new read of 0x300 completes normally in 5 cycles.
- Consecutive load then store, both with `ext_ready=1`:
  - store accepted in the cycle after the load's DONE;
  - no strobe overlap;
  - total stall 5+1+N cycles.

Source files
------------

// File: rtl/mem_byte_bridge.sv
// Splits 32-bit MEM-stage loads/stores into single-byte transfers on an 8-bit
// external bus, assembling load data and stalling the pipeline until done.
module mem_byte_bridge (
  input  logic        CLK,
  input  logic        RST,
  input  logic        read_op,
  input  logic        write_op,
  input  logic [31:0] addr,
  input  logic [3:0]  mask,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stallreq,
  output logic [31:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_re,
  output logic        ext_we,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ready
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  idx_q, idx_d;

  logic        req;
  logic [2:0]  first_byte;
  logic [2:0]  next_byte;
  logic        addr_lo_unused;

  // Lowest set mask bit at or above start; MSB flags whether one was found.
  function automatic logic [2:0] lowest_from(input logic [3:0] m, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (3'(i) >= start)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign req            = read_op | write_op;
  assign first_byte     = lowest_from(mask, 3'd0);
  assign next_byte      = lowest_from(mask_q, {1'b0, idx_q} + 3'd1);
  assign addr_lo_unused = ^addr[1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          is_write_d = write_op;
          addr_d     = addr[31:2];
          wdata_d    = wdata;
          // Reads always walk all four bytes, so they carry a full mask.
          mask_d     = write_op ? mask : 4'hF;
          if (write_op) begin
            idx_d   = first_byte[1:0];
            state_d = first_byte[2] ? S_XFER : S_DONE;
          end else begin
            idx_d   = 2'd0;
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (ext_ready) begin
          if (!is_write_q) rdata_d[{idx_q, 3'b000} +: 8] = ext_rdata;
          if (next_byte[2]) idx_d = next_byte[1:0];
          else              state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
    end
  end

  assign rdata     = rdata_q;
  assign ext_addr  = {addr_q, idx_q};
  assign ext_wdata = wdata_q[{idx_q, 3'b000} +: 8];
  assign ext_re    = (state_q == S_XFER) && !is_write_q;
  assign ext_we    = (state_q == S_XFER) &&  is_write_q;
  // Gated by RST so a request held during reset does not stall the pipeline.
  assign stallreq  = !RST && (((state_q == S_IDLE) && req) || (state_q == S_XFER));

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Directed bench for mem_byte_bridge: drives MEM-stage requests, models the
// byte-wide external memory and compares bus traffic and results to constants.
module tb_mem_byte_bridge;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        read_op = 1'b0, write_op = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata, ext_addr;
  logic        stallreq, ext_re, ext_we;
  logic [7:0]  ext_wdata, ext_rdata;
  logic        ext_ready = 1'b1;

  int n_checks = 0, n_errors = 0;

  logic [7:0]  mem [16];
  logic [31:0] xa[$];
  logic [7:0]  xd[$];
  int          re_cnt, we_cnt, overlap, c0_strobe, c0_stall;
  int          addr_cnt [4];
  int          stalls, done_cyc, stalls2, done2;

  mem_byte_bridge dut (
    .CLK(CLK), .RST(RST), .read_op(read_op), .write_op(write_op), .addr(addr),
    .mask(mask), .wdata(wdata), .rdata(rdata), .stallreq(stallreq),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_re(ext_re), .ext_we(ext_we),
    .ext_rdata(ext_rdata), .ext_ready(ext_ready)
  );

  always #5 CLK = ~CLK;

  assign ext_rdata = mem[{ext_addr[9:8], ext_addr[1:0]}];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one request starting just after a rising edge in IDLE. Byte wait_byte
  // sees ext_ready low for wait_cnt cycles. Returns when DONE has been seen.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d,
                        input int wait_byte, input int wait_cnt,
                        output int st, output int dc);
    int c, waited;
    bit done;
    c = 0; waited = 0; done = 0; st = 0; dc = -1;
    xa.delete(); xd.delete();
    re_cnt = 0; we_cnt = 0; overlap = 0; c0_strobe = 0; c0_stall = 0;
    for (int i = 0; i < 4; i++) addr_cnt[i] = 0;
    write_op = wr; read_op = rd; addr = a; mask = m; wdata = d; ext_ready = 1'b1;
    while (!done && c < 40) begin
      @(negedge CLK);
      if (stallreq) st++;
      if (c == 0) begin
        c0_stall  = int'(stallreq);
        c0_strobe = int'(ext_re | ext_we);
      end
      if (ext_re && ext_we) overlap++;
      if (ext_re || ext_we) begin
        addr_cnt[ext_addr[1:0]]++;
        if (int'(ext_addr[1:0]) == wait_byte && waited < wait_cnt) begin
          ext_ready = 1'b0;
          waited++;
        end else begin
          ext_ready = 1'b1;
          xa.push_back(ext_addr);
          xd.push_back(ext_wdata);
          if (ext_re) re_cnt++;
          if (ext_we) we_cnt++;
        end
      end else begin
        ext_ready = 1'b1;
        if (c > 0 && !stallreq) begin
          done = 1;
          dc = c;
        end
      end
      @(posedge CLK); #1;
      if (c == 0) begin
        read_op = 1'b0;
        write_op = 1'b0;
      end
      c++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) mem[b*4+i] = 8'((b*4 + i + 1) * 17);
    end
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    mem[12] = 8'hA1; mem[13] = 8'hB2; mem[14] = 8'hC3; mem[15] = 8'hD4;

    #2 RST = 1'b1;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);
    chk("rst_re", {31'd0, ext_re}, 32'd0);
    chk("rst_we", {31'd0, ext_we}, 32'd0);
    chk("rst_addr", ext_addr, 32'h0);
    chk("rst_wdata", {24'd0, ext_wdata}, 32'h0);
    #10 RST = 1'b0;
    @(posedge CLK); #1;

    // Full-word read of 0x100
    run_op(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, -1, 0, stalls, done_cyc);
    chk("rd_c0_stall", c0_stall, 1);
    chk("rd_c0_nostrobe", c0_strobe, 0);
    chk("rd_done", done_cyc, 5);
    chk("rd_stalls", stalls, 5);
    chk("rd_re_cnt", re_cnt, 4);
    chk("rd_we_cnt", we_cnt, 0);
    for (int i = 0; i < 4; i++) chk("rd_addr", (i < xa.size()) ? xa[i] : 32'hX, 32'h100 + i);
    chk("rd_rdata", rdata, 32'h44332211);

    // Sparse-mask write
    run_op(1'b1, 1'b0, 32'h206, 4'b0101, 32'hAABBCCDD, -1, 0, stalls, done_cyc);
    chk("wr_we_cnt", we_cnt, 2);
    chk("wr_re_cnt", re_cnt, 0);
    chk("wr_a0", (xa.size() > 0) ? xa[0] : 32'hX, 32'h204);
    chk("wr_d0", (xd.size() > 0) ? {24'd0, xd[0]} : 32'hX, 32'hDD);
    chk("wr_a1", (xa.size() > 1) ? xa[1] : 32'hX, 32'h206);
    chk("wr_d1", (xd.size() > 1) ? {24'd0, xd[1]} : 32'hX, 32'hBB);
    chk("wr_done", done_cyc, 3);
    chk("wr_rdata_kept", rdata, 32'h44332211);

    // Read with byte 1 stalled two cycles
    run_op(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1, 2, stalls, done_cyc);
    chk("wt_byte1_cycles", addr_cnt[1], 3);
    chk("wt_done", done_cyc, 7);
    chk("wt_stalls", stalls, 7);
    chk("wt_rdata", rdata, 32'h04030201);

    // Empty-mask write, then simultaneous read/write
    run_op(1'b1, 1'b0, 32'h40, 4'b0000, 32'h12345678, -1, 0, stalls, done_cyc);
    chk("m0_we_cnt", we_cnt, 0);
    chk("m0_stalls", stalls, 1);
    chk("m0_done", done_cyc, 1);
    run_op(1'b1, 1'b1, 32'h120, 4'b1000, 32'h5A000000, -1, 0, stalls, done_cyc);
    chk("both_we_cnt", we_cnt, 1);
    chk("both_re_cnt", re_cnt, 0);
    chk("both_addr", (xa.size() > 0) ? xa[0] : 32'hX, 32'h123);
    chk("both_data", (xd.size() > 0) ? {24'd0, xd[0]} : 32'hX, 32'h5A);
    chk("both_done", done_cyc, 2);
    chk("both_rdata_kept", rdata, 32'h04030201);

    // Asynchronous reset while byte 2 is waiting
    read_op = 1'b1; addr = 32'h100; ext_ready = 1'b1;
    @(posedge CLK); #1 read_op = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1 ext_ready = 1'b0;
    #1;
    chk("ar_pre_re", {31'd0, ext_re}, 32'd1);
    chk("ar_pre_addr", ext_addr, 32'h102);
    read_op = 1'b1;
    #1 RST = 1'b1;
    #1;
    chk("ar_re", {31'd0, ext_re}, 32'd0);
    chk("ar_stall", {31'd0, stallreq}, 32'd0);
    chk("ar_rdata", rdata, 32'h0);
    read_op = 1'b0;
    #13 RST = 1'b0;
    @(posedge CLK); #1;
    run_op(1'b0, 1'b1, 32'h300, 4'h0, 32'h0, -1, 0, stalls, done_cyc);
    chk("ar_post_done", done_cyc, 5);
    chk("ar_post_rdata", rdata, 32'hD4C3B2A1);

    // Back-to-back load then store
    run_op(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, -1, 0, stalls, done_cyc);
    chk("bb_ld_overlap", overlap, 0);
    run_op(1'b1, 1'b0, 32'h208, 4'b0011, 32'h0000BEEF, -1, 0, stalls2, done2);
    chk("bb_st_c0_stall", c0_stall, 1);
    chk("bb_st_overlap", overlap, 0);
    chk("bb_st_done", done2, 3);
    chk("bb_total_stall", stalls + stalls2, 8);
    chk("bb_st_d1", (xd.size() > 1) ? {24'd0, xd[1]} : 32'hX, 32'hBE);
    chk("bb_rdata", rdata, 32'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
